// File: rtl/facelet_fb_writer_pkg.sv
// Shared definitions for the facelet framebuffer writer.
// Holds framebuffer geometry, the FSM state encoding, the face-origin
// table, the colour palette and the facelet-to-pixel address helper.
package facelet_fb_writer_pkg;

  localparam int unsigned FB_W       = 64;
  localparam int unsigned FB_H       = 48;
  localparam int unsigned FB_SIZE    = FB_W * FB_H;
  localparam int unsigned FACELETS   = 54;
  localparam int unsigned NUM_FACES  = 6;
  localparam int unsigned FACE_CELLS = 9;
  localparam int unsigned CELL_PITCH = 3;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned RGB_W  = 24;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAccept,
    StWrite,
    StDone
  } state_e;

  // Top-left pixel of each face, indexed U, L, F, R, B, D.
  localparam logic [5:0] FACE_OX [NUM_FACES] = '{6'd12, 6'd2, 6'd12, 6'd22, 6'd32, 6'd12};
  localparam logic [5:0] FACE_OY [NUM_FACES] = '{6'd10, 6'd20, 6'd20, 6'd20, 6'd20, 6'd30};

  localparam logic [RGB_W-1:0] PAL_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] PAL_ORANGE  = 24'hFF4000;
  localparam logic [RGB_W-1:0] PAL_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] PAL_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] PAL_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] PAL_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] PAL_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] PAL_BLACK   = 24'h000000;

  function automatic logic facelet_in_range(logic [2:0] face, logic [3:0] idx);
    return (face < 3'(NUM_FACES)) && (idx < 4'(FACE_CELLS));
  endfunction

  // Address of one pixel of a facelet's 2x2 block; step[0]=dx, step[1]=dy.
  // Out-of-range words are never written, so they just map to face 0 / cell 0.
  function automatic logic [ADDR_W-1:0] facelet_pixel(logic [2:0] face, logic [3:0] idx,
                                                      logic [1:0] step);
    int unsigned f;
    int unsigned i;
    int unsigned x;
    int unsigned y;
    f = facelet_in_range(face, idx) ? int'(face) : 0;
    i = facelet_in_range(face, idx) ? int'(idx) : 0;
    x = int'(FACE_OX[f]) + CELL_PITCH * (i % 3) + int'(step[0]);
    y = int'(FACE_OY[f]) + CELL_PITCH * (i / 3) + int'(step[1]);
    return ADDR_W'(y * FB_W + x);
  endfunction

endpackage

// File: rtl/facelet_fb_writer_if.sv
// Facelet input stream and framebuffer write port.
//   fc_valid/fc_ready : facelet word handshake, fc_face/fc_idx/fc_color payload
//   mem_address/mem_data/mem_wren : framebuffer write port
// master = facelet source / framebuffer sink, slave = the writer.
interface facelet_fb_writer_if;
  import facelet_fb_writer_pkg::*;

  logic              fc_valid;
  logic              fc_ready;
  logic [2:0]        fc_face;
  logic [3:0]        fc_idx;
  logic [2:0]        fc_color;
  logic [ADDR_W-1:0] mem_address;
  logic [RGB_W-1:0]  mem_data;
  logic              mem_wren;

  modport master (
    output fc_valid, fc_face, fc_idx, fc_color,
    input  fc_ready, mem_address, mem_data, mem_wren
  );

  modport slave (
    input  fc_valid, fc_face, fc_idx, fc_color,
    output fc_ready, mem_address, mem_data, mem_wren
  );

endinterface

// File: rtl/facelet_palette.sv
// Colour decode: 3-bit facelet colour code to 24-bit {R,G,B}. Combinational.
//   code : packed colour code
//   rgb  : framebuffer pixel value
module facelet_palette
  import facelet_fb_writer_pkg::*;
(
  input  logic [2:0]       code,
  output logic [RGB_W-1:0] rgb
);

  always_comb begin
    rgb = PAL_MAGENTA;
    case (code)
      3'b000:  rgb = PAL_WHITE;
      3'b001:  rgb = PAL_ORANGE;
      3'b010:  rgb = PAL_GREEN;
      3'b011:  rgb = PAL_RED;
      3'b100:  rgb = PAL_BLUE;
      3'b101:  rgb = PAL_YELLOW;
      default: rgb = PAL_MAGENTA;
    endcase
  end

endmodule

// File: rtl/facelet_fb_writer.sv
// Draws a 54-facelet cube net into a 64x48 framebuffer.
// A start pulse clears the framebuffer to black, then 54 facelet words are
// accepted one at a time; each valid word is drawn as a 2x2 pixel block,
// each out-of-range word is dropped with an err pulse. done pulses once
// the 54th word has been handled.
//   clk, rst   : clock, asynchronous active-low reset
//   start      : redraw request (IDLE only)
//   bus        : facelet stream in, framebuffer write port out
//   busy       : not IDLE
//   done, err  : single-cycle status pulses
// All outputs are registered.
module facelet_fb_writer
  import facelet_fb_writer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  facelet_fb_writer_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e            state_q;
  logic [5:0]        count_q;
  logic [1:0]        step_q;
  logic [2:0]        face_q;
  logic [3:0]        idx_q;
  logic [2:0]        color_q;
  logic              fc_ready_q;
  logic              mem_wren_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [RGB_W-1:0]  mem_data_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              accept;
  logic              in_range;
  logic              last_word;
  logic [2:0]        sel_face;
  logic [3:0]        sel_idx;
  logic [2:0]        sel_color;
  logic [1:0]        step_n;
  logic [ADDR_W-1:0] pix_addr;
  logic [RGB_W-1:0]  pal_rgb;

  // The first pixel goes out the cycle after acceptance, so in ACCEPT the
  // address and colour come straight from the bus; in WRITE from the latches.
  always_comb begin
    accept    = bus.fc_valid && fc_ready_q;
    sel_face  = (state_q == StAccept) ? bus.fc_face  : face_q;
    sel_idx   = (state_q == StAccept) ? bus.fc_idx   : idx_q;
    sel_color = (state_q == StAccept) ? bus.fc_color : color_q;
    step_n    = (state_q == StAccept) ? 2'd0 : step_q + 2'd1;
    in_range  = facelet_in_range(bus.fc_face, bus.fc_idx);
    last_word = (count_q == 6'(FACELETS - 1));
    pix_addr  = facelet_pixel(sel_face, sel_idx, step_n);
  end

  facelet_palette u_palette (
    .code (sel_color),
    .rgb  (pal_rgb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      count_q       <= '0;
      step_q        <= '0;
      face_q        <= '0;
      idx_q         <= '0;
      color_q       <= '0;
      fc_ready_q    <= 1'b0;
      mem_wren_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q       <= StClear;
            busy_q        <= 1'b1;
            count_q       <= '0;
            mem_wren_q    <= 1'b1;
            mem_address_q <= '0;
            mem_data_q    <= PAL_BLACK;
          end
        end

        StClear: begin
          if (mem_address_q == ADDR_W'(FB_SIZE - 1)) begin
            state_q    <= StAccept;
            mem_wren_q <= 1'b0;
            fc_ready_q <= 1'b1;
          end else begin
            mem_address_q <= mem_address_q + 1'b1;
          end
        end

        StAccept: begin
          if (count_q == 6'(FACELETS)) begin
            // Only reached when the final word was out of range.
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (accept) begin
            face_q  <= bus.fc_face;
            idx_q   <= bus.fc_idx;
            color_q <= bus.fc_color;
            count_q <= count_q + 1'b1;
            if (in_range) begin
              state_q       <= StWrite;
              fc_ready_q    <= 1'b0;
              step_q        <= '0;
              mem_wren_q    <= 1'b1;
              mem_address_q <= pix_addr;
              mem_data_q    <= pal_rgb;
            end else begin
              err_q <= 1'b1;
              // Stop taking words after the last one so its err cycle can
              // precede DONE.
              if (last_word) begin
                fc_ready_q <= 1'b0;
              end
            end
          end
        end

        StWrite: begin
          if (step_q == 2'd3) begin
            mem_wren_q <= 1'b0;
            if (count_q == 6'(FACELETS)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StAccept;
              fc_ready_q <= 1'b1;
            end
          end else begin
            step_q        <= step_n;
            mem_address_q <= pix_addr;
          end
        end

        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q    <= StIdle;
          busy_q     <= 1'b0;
          fc_ready_q <= 1'b0;
          mem_wren_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fc_ready    = fc_ready_q;
  assign bus.mem_wren    = mem_wren_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data    = mem_data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_facelet_fb_writer.sv
// Self-checking bench for facelet_fb_writer: reset state, framebuffer clear,
// a table of hand-computed facelet words, streamed redraws and reset mid-clear.
module tb_facelet_fb_writer;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic err;

  int checks;
  int errors;

  facelet_fb_writer_if bus ();

  facelet_fb_writer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [2:0]  face;
    logic [3:0]  idx;
    logic [2:0]  color;
    logic        is_err;
    logic [14:0] a0;
    logic [14:0] a1;
    logic [14:0] a2;
    logic [14:0] a3;
    logic [23:0] rgb;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_word(input int k);
    bus.fc_face  = 3'(k / 9);
    bus.fc_idx   = 4'(k % 9);
    bus.fc_color = 3'(k % 8);
  endtask

  // Start pulse, then expect 3072 black writes at 0..3071 and fc_ready after.
  task automatic do_clear();
    int bad;
    bad = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3072; i++) begin
      if (!(bus.mem_wren === 1'b1 && bus.mem_address === 15'(i) &&
            bus.mem_data === 24'h000000 && busy === 1'b1 && bus.fc_ready === 1'b0))
        bad++;
      tick();
    end
    chk("clear_writes_bad", bad, 0);
    chk("clear_ready", bus.fc_ready, 1'b1);
    chk("clear_wren_off", bus.mem_wren, 1'b0);
  endtask

  // Words first..first+n-1 with fc_valid held high; last word is k=53
  // (D face idx 8 colour 101 -> 2322,2323,2386,2387 FFFF00).
  task automatic stream(input int first, input int n);
    int acc;
    int cyc;
    int last;
    int guard;
    int k;
    acc = 0; cyc = 0; last = -1; guard = 0; k = first;
    set_word(k);
    bus.fc_valid = 1'b1;
    while (acc < n && guard < 10 * n + 20) begin
      if (bus.fc_ready === 1'b1) begin
        if (last >= 0) chk("accept_spacing", cyc - last, 5);
        last = cyc;
        acc++;
        tick();
        k++;
        set_word(k);
      end else begin
        tick();
      end
      cyc++;
      guard++;
    end
    chk("stream_accepts", acc, n);
    chk("last_w0_wren", bus.mem_wren, 1'b1);
    chk("last_w0_addr", bus.mem_address, 15'd2322);
    tick();
    tick();
    tick();
    chk("last_w3_wren", bus.mem_wren, 1'b1);
    chk("last_w3_addr", bus.mem_address, 15'd2387);
    chk("last_w3_data", bus.mem_data, 24'hFFFF00);
    chk("last_w3_done", done, 1'b0);
    tick();
    chk("done_pulse", done, 1'b1);
    chk("done_wren", bus.mem_wren, 1'b0);
    chk("done_busy", busy, 1'b1);
    chk("done_ready", bus.fc_ready, 1'b0);
    tick();
    chk("after_done", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_ready", bus.fc_ready, 1'b0);
    bus.fc_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{face: 3'd2, idx: 4'd0, color: 3'd3, is_err: 1'b0,
                 a0: 15'd1292, a1: 15'd1293, a2: 15'd1356, a3: 15'd1357, rgb: 24'hFF0000};
    vecs[1]  = '{face: 3'd0, idx: 4'd8, color: 3'd5, is_err: 1'b0,
                 a0: 15'd1042, a1: 15'd1043, a2: 15'd1106, a3: 15'd1107, rgb: 24'hFFFF00};
    vecs[2]  = '{face: 3'd6, idx: 4'd2, color: 3'd0, is_err: 1'b1,
                 a0: 15'd0, a1: 15'd0, a2: 15'd0, a3: 15'd0, rgb: 24'h0};
    vecs[3]  = '{face: 3'd1, idx: 4'd4, color: 3'd1, is_err: 1'b0,
                 a0: 15'd1477, a1: 15'd1478, a2: 15'd1541, a3: 15'd1542, rgb: 24'hFF4000};
    vecs[4]  = '{face: 3'd5, idx: 4'd9, color: 3'd0, is_err: 1'b1,
                 a0: 15'd0, a1: 15'd0, a2: 15'd0, a3: 15'd0, rgb: 24'h0};
    vecs[5]  = '{face: 3'd4, idx: 4'd2, color: 3'd7, is_err: 1'b0,
                 a0: 15'd1318, a1: 15'd1319, a2: 15'd1382, a3: 15'd1383, rgb: 24'hFF00FF};
    vecs[6]  = '{face: 3'd3, idx: 4'd6, color: 3'd4, is_err: 1'b0,
                 a0: 15'd1686, a1: 15'd1687, a2: 15'd1750, a3: 15'd1751, rgb: 24'h0000FF};
    vecs[7]  = '{face: 3'd5, idx: 4'd0, color: 3'd2, is_err: 1'b0,
                 a0: 15'd1932, a1: 15'd1933, a2: 15'd1996, a3: 15'd1997, rgb: 24'h00FF00};
    vecs[8]  = '{face: 3'd0, idx: 4'd0, color: 3'd0, is_err: 1'b0,
                 a0: 15'd652, a1: 15'd653, a2: 15'd716, a3: 15'd717, rgb: 24'hFFFFFF};
    vecs[9]  = '{face: 3'd7, idx: 4'd15, color: 3'd6, is_err: 1'b1,
                 a0: 15'd0, a1: 15'd0, a2: 15'd0, a3: 15'd0, rgb: 24'h0};
    vecs[10] = '{face: 3'd2, idx: 4'd5, color: 3'd6, is_err: 1'b0,
                 a0: 15'd1490, a1: 15'd1491, a2: 15'd1554, a3: 15'd1555, rgb: 24'hFF00FF};

    rst = 1'b0;
    start = 1'b0;
    bus.fc_valid = 1'b0;
    bus.fc_face = '0;
    bus.fc_idx = '0;
    bus.fc_color = '0;
    tick();
    tick();
    chk("rst_ready", bus.fc_ready, 1'b0);
    chk("rst_wren", bus.mem_wren, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_addr", bus.mem_address, 15'd0);
    chk("rst_data", bus.mem_data, 24'd0);
    rst = 1'b1;
    tick();

    // Redraw 1: clear, table words, then the remaining words streamed.
    do_clear();
    for (int i = 0; i < NVEC; i++) begin
      int n;
      n = 0;
      while (bus.fc_ready !== 1'b1 && n < 50) begin
        tick();
        n++;
      end
      chk("vec_ready_wait", (n < 50) ? 1 : 0, 1);
      bus.fc_face  = vecs[i].face;
      bus.fc_idx   = vecs[i].idx;
      bus.fc_color = vecs[i].color;
      bus.fc_valid = 1'b1;
      tick();
      bus.fc_valid = 1'b0;
      if (vecs[i].is_err) begin
        chk("err_pulse", err, 1'b1);
        chk("err_no_wren", bus.mem_wren, 1'b0);
        chk("err_ready", bus.fc_ready, 1'b1);
        tick();
        chk("err_once", err, 1'b0);
        chk("err_no_wren2", bus.mem_wren, 1'b0);
      end else begin
        for (int j = 0; j < 4; j++) begin
          logic [14:0] ea;
          ea = (j == 0) ? vecs[i].a0 : (j == 1) ? vecs[i].a1 : (j == 2) ? vecs[i].a2 : vecs[i].a3;
          chk("wr_wren", bus.mem_wren, 1'b1);
          chk("wr_addr", bus.mem_address, ea);
          chk("wr_data", bus.mem_data, vecs[i].rgb);
          chk("wr_no_err", err, 1'b0);
          tick();
        end
        chk("post_wr_wren", bus.mem_wren, 1'b0);
        chk("post_wr_ready", bus.fc_ready, 1'b1);
        chk("post_wr_addr_hold", bus.mem_address, vecs[i].a3);
        chk("post_wr_data_hold", bus.mem_data, vecs[i].rgb);
      end
    end

    // start in ACCEPT must not restart the clear.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored_ready", bus.fc_ready, 1'b1);
    chk("start_ignored_wren", bus.mem_wren, 1'b0);
    tick();
    chk("start_ignored_wren2", bus.mem_wren, 1'b0);
    chk("start_ignored_busy", busy, 1'b1);

    stream(NVEC, 54 - NVEC);

    // Redraw 2: all 54 words back to back.
    tick();
    do_clear();
    stream(0, 54);

    // Redraw 3: reset in the middle of the clear.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_clear_wren", bus.mem_wren, 1'b1);
    rst = 1'b0;
    #1;
    chk("async_rst_wren", bus.mem_wren, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_addr", bus.mem_address, 15'd0);
    #3;
    rst = 1'b1;
    tick();
    chk("post_rst_wren", bus.mem_wren, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_ready", bus.fc_ready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
